esdi_serial_link: RTL and testbench

Bit-level ESDI serial command/status link engine. Sits between the ESDI connector pins and `axi_esdi_cmd_controller`. Runs the TRANSFER REQ / TRANSFER ACK handshake, deserialises 17-bit host command frames into parallel words, and serialises parallel status/configuration words back to the host. Parity generation/checking and frame timeout are handled here so the controller only sees whole words.

---
 rtl/esdi_pkg.sv | 23 ++
 rtl/esdi_sync.sv | 37 +++
 rtl/esdi_serial_link.sv | 217 +++++++++++++++++++++
 tb/tb_esdi_serial_link.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esdi_pkg.sv
// Shared ESDI serial link definitions.
// Holds the frame geometry, the link FSM state encoding and the odd-parity helper. Both the
// serial link engine and the command controller import this package.
package esdi_pkg;

  localparam int unsigned ESDI_WORD_BITS  = 16;
  localparam int unsigned ESDI_FRAME_BITS = 17;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAck,
    StRelease,
    StGap,
    StDone
  } esdi_state_e;

  // Parity bit that makes the total count of ones over word + parity odd.
  function automatic logic odd_parity(input logic [ESDI_WORD_BITS-1:0] word);
    return ~^word;
  endfunction

endpackage

// File: rtl/esdi_sync.sv
// N-flop synchroniser for asynchronous single-bit inputs.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, clears every stage to 0
//   d_i    - asynchronous input
//   q_o    - synchronised output (Stages clocks of latency)
module esdi_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;
  logic [Stages-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d_i;
    for (int unsigned i = 1; i < Stages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/esdi_serial_link.sv
// Bit-level ESDI serial command/status link engine.
// Runs the TRANSFER REQ / ACK handshake, deserialises 17-bit command frames (16 data bits MSB
// first + odd parity) and serialises buffered status words back to the host.
// Ports:
//   csr_aclk / csr_aresetn                 - clock, asynchronous active-low reset
//   esdi_transfer_req / esdi_command_data  - asynchronous host pins (synchronised here)
//   esdi_transfer_ack / esdi_confstat_data - link outputs to the host
//   cmd_valid / cmd_ready / cmd_data / cmd_parity_err - received command word stream
//   stat_valid / stat_ready / stat_data    - status word input (single-entry buffer)
//   frame_err                              - one-cycle pulse on inter-bit timeout
module esdi_serial_link
  import esdi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_DELAY   = 6,
  parameter int unsigned REL_DELAY   = 6,
  parameter int unsigned TIMEOUT     = 40
) (
  input  logic        csr_aclk,
  input  logic        csr_aresetn,
  input  logic        esdi_transfer_req,
  input  logic        esdi_command_data,
  output logic        esdi_transfer_ack,
  output logic        esdi_confstat_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [15:0] cmd_data,
  output logic        cmd_parity_err,
  input  logic        stat_valid,
  output logic        stat_ready,
  input  logic [15:0] stat_data,
  output logic        frame_err
);

  localparam int unsigned CntW = $clog2(ACK_DELAY + REL_DELAY + TIMEOUT + 1);

  logic req_s;
  logic data_s;

  esdi_sync #(
    .Stages(SYNC_STAGES)
  ) u_sync_req (
    .clk_i (csr_aclk),
    .rst_ni(csr_aresetn),
    .d_i   (esdi_transfer_req),
    .q_o   (req_s)
  );

  esdi_sync #(
    .Stages(SYNC_STAGES)
  ) u_sync_data (
    .clk_i (csr_aclk),
    .rst_ni(csr_aresetn),
    .d_i   (esdi_command_data),
    .q_o   (data_s)
  );

  esdi_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic            dir_stat_q, dir_stat_d;
  logic [16:0]     shreg_q, shreg_d;
  logic            ack_q, ack_d;
  logic            confstat_q, confstat_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [15:0]     cmd_data_q, cmd_data_d;
  logic            cmd_perr_q, cmd_perr_d;
  logic            stat_full_q, stat_full_d;
  logic [15:0]     stat_word_q, stat_word_d;
  logic            stat_par_q, stat_par_d;
  logic            frame_err_q, frame_err_d;
  logic [3:0]      bit_idx;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    dir_stat_d  = dir_stat_q;
    shreg_d     = shreg_q;
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    cmd_perr_d  = cmd_perr_q;
    stat_full_d = stat_full_q;
    stat_word_d = stat_word_q;
    stat_par_d  = stat_par_q;
    frame_err_d = 1'b0;

    // Parity is fixed at load time so the serialiser never recomputes it mid-frame.
    if (stat_valid && !stat_full_q) begin
      stat_full_d = 1'b1;
      stat_word_d = stat_data;
      stat_par_d  = odd_parity(stat_data);
    end

    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // Direction is decided here, at bit 0; a pending command word stalls command frames.
        if (req_s && (stat_full_q || !cmd_valid_q)) begin
          dir_stat_d = stat_full_q;
          state_d    = StSetup;
          cnt_d      = '0;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(ACK_DELAY - 1)) begin
          state_d = StAck;
          if (!dir_stat_q) begin
            shreg_d = {shreg_q[15:0], data_s};
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAck: begin
        if (!req_s) begin
          state_d = StRelease;
          cnt_d   = '0;
        end
      end
      StRelease: begin
        if (cnt_q == CntW'(REL_DELAY - 1)) begin
          cnt_d = '0;
          if (bit_cnt_q == 5'(ESDI_FRAME_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = StDone;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = StGap;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (req_s) begin
          state_d = StSetup;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // Abort: partial command bits are simply overwritten by the next full frame, and a
          // status word stays buffered to be resent from bit 15.
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        if (dir_stat_q) begin
          stat_full_d = 1'b0;
        end else begin
          cmd_valid_d = 1'b1;
          cmd_data_d  = shreg_q[16:1];
          cmd_perr_d  = ~^shreg_q;
        end
      end
      default: state_d = StIdle;
    endcase

    ack_d   = (state_d == StAck) || (state_d == StRelease);
    // Bits 0..15 map to word bits 15..0; bit 16 is the parity bit.
    bit_idx = ~bit_cnt_d[3:0];
    if (dir_stat_d && (state_d == StSetup || state_d == StAck || state_d == StRelease)) begin
      confstat_d = bit_cnt_d[4] ? stat_par_q : stat_word_q[bit_idx];
    end else begin
      confstat_d = 1'b0;
    end
  end

  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      dir_stat_q  <= 1'b0;
      shreg_q     <= '0;
      ack_q       <= 1'b0;
      confstat_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      cmd_perr_q  <= 1'b0;
      stat_full_q <= 1'b0;
      stat_word_q <= '0;
      stat_par_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      dir_stat_q  <= dir_stat_d;
      shreg_q     <= shreg_d;
      ack_q       <= ack_d;
      confstat_q  <= confstat_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      cmd_perr_q  <= cmd_perr_d;
      stat_full_q <= stat_full_d;
      stat_word_q <= stat_word_d;
      stat_par_q  <= stat_par_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign esdi_transfer_ack  = ack_q;
  assign esdi_confstat_data = confstat_q;
  assign cmd_valid          = cmd_valid_q;
  assign cmd_data           = cmd_data_q;
  assign cmd_parity_err     = cmd_perr_q;
  assign stat_ready         = ~stat_full_q;
  assign frame_err          = frame_err_q;

endmodule

// File: tb/tb_esdi_serial_link.sv
// Directed self-checking bench for esdi_serial_link at default parameters.
module tb_esdi_serial_link;

  logic        csr_aclk = 1'b0;
  logic        csr_aresetn;
  logic        esdi_transfer_req;
  logic        esdi_command_data;
  logic        esdi_transfer_ack;
  logic        esdi_confstat_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic        cmd_parity_err;
  logic        stat_valid;
  logic        stat_ready;
  logic [15:0] stat_data;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;

  localparam int Bound = 60;

  esdi_serial_link dut (
    .csr_aclk          (csr_aclk),
    .csr_aresetn       (csr_aresetn),
    .esdi_transfer_req (esdi_transfer_req),
    .esdi_command_data (esdi_command_data),
    .esdi_transfer_ack (esdi_transfer_ack),
    .esdi_confstat_data(esdi_confstat_data),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_data          (cmd_data),
    .cmd_parity_err    (cmd_parity_err),
    .stat_valid        (stat_valid),
    .stat_ready        (stat_ready),
    .stat_data         (stat_data),
    .frame_err         (frame_err)
  );

  always #5 csr_aclk = ~csr_aclk;

  // One host bit: raise REQ with data, wait for ACK, drop REQ, wait for ACK release.
  // Entered and left 1 time unit after a rising edge.
  task automatic host_bit(input logic b, output int rise_n, output int fall_n,
                          output logic conf);
    esdi_command_data = b;
    esdi_transfer_req = 1'b1;
    rise_n = 0;
    while (esdi_transfer_ack !== 1'b1 && rise_n < Bound) begin
      @(posedge csr_aclk); #1; rise_n++;
    end
    conf = esdi_confstat_data;
    esdi_transfer_req = 1'b0;
    fall_n = 0;
    while (esdi_transfer_ack !== 1'b0 && fall_n < Bound) begin
      @(posedge csr_aclk); #1; fall_n++;
    end
  endtask

  // Sends frame[16], frame[15], ... for nbits bits; checks 9-clock ACK rise/fall each bit.
  task automatic send_bits(input logic [16:0] frame, input int nbits,
                           output logic [16:0] conf_seq);
    int   r, f;
    logic c;
    conf_seq = '0;
    for (int i = 0; i < nbits; i++) begin
      host_bit(frame[16-i], r, f, c);
      conf_seq = {conf_seq[15:0], c};
      checks++;
      if (r !== 9) begin
        failures++;
        $display("FAIL ack_rise bit%0d: got %0d clocks, want 9", i, r);
      end
      checks++;
      if (f !== 9) begin
        failures++;
        $display("FAIL ack_fall bit%0d: got %0d clocks, want 9", i, f);
      end
    end
  endtask

  task automatic consume_cmd(input string name);
    cmd_ready = 1'b1;
    @(posedge csr_aclk); #1;
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_consume: cmd_valid=%b want 0", name, cmd_valid);
    end
  endtask

  // Sends a full command frame then checks cmd_valid timing, data and parity flag.
  task automatic cmd_frame(input string name, input logic [15:0] word, input logic par,
                           input logic exp_perr);
    logic [16:0] seq;
    send_bits({word, par}, 17, seq);
    checks++;
    if (cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid_early: cmd_valid=%b want 0 at ack fall", name, cmd_valid);
    end
    @(posedge csr_aclk); #1;
    checks++;
    if (cmd_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid: cmd_valid=%b want 1", name, cmd_valid);
    end
    checks++;
    if (cmd_data !== word) begin
      failures++;
      $display("FAIL %s_data: got %h want %h", name, cmd_data, word);
    end
    checks++;
    if (cmd_parity_err !== exp_perr) begin
      failures++;
      $display("FAIL %s_perr: got %b want %b", name, cmd_parity_err, exp_perr);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (esdi_transfer_ack !== 1'b0) begin
      failures++; $display("FAIL %s_ack: got %b want 0", name, esdi_transfer_ack);
    end
    checks++;
    if (esdi_confstat_data !== 1'b0) begin
      failures++; $display("FAIL %s_confstat: got %b want 0", name, esdi_confstat_data);
    end
    checks++;
    if (cmd_valid !== 1'b0) begin
      failures++; $display("FAIL %s_cmd_valid: got %b want 0", name, cmd_valid);
    end
    checks++;
    if (cmd_data !== 16'h0000) begin
      failures++; $display("FAIL %s_cmd_data: got %h want 0000", name, cmd_data);
    end
    checks++;
    if (cmd_parity_err !== 1'b0) begin
      failures++; $display("FAIL %s_perr: got %b want 0", name, cmd_parity_err);
    end
    checks++;
    if (stat_ready !== 1'b1) begin
      failures++; $display("FAIL %s_stat_ready: got %b want 1", name, stat_ready);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      failures++; $display("FAIL %s_frame_err: got %b want 0", name, frame_err);
    end
  endtask

  task automatic test_reset;
    csr_aresetn       = 1'b0;
    esdi_transfer_req = 1'b0;
    esdi_command_data = 1'b0;
    cmd_ready         = 1'b0;
    stat_valid        = 1'b0;
    stat_data         = 16'h0000;
    repeat (3) @(posedge csr_aclk);
    #1;
    check_reset_values("reset");
    csr_aresetn = 1'b1;
    repeat (2) @(posedge csr_aclk);
    #1;
  endtask

  task automatic test_cmd_good;
    // 0x1234 has five ones, so parity 0 gives an odd total.
    cmd_frame("cmd_good", 16'h1234, 1'b0, 1'b0);
    consume_cmd("cmd_good");
  endtask

  task automatic test_cmd_parity_err;
    cmd_frame("cmd_perr", 16'h1234, 1'b1, 1'b1);
    consume_cmd("cmd_perr");
  endtask

  task automatic test_status;
    logic [16:0] seq;
    logic [16:0] exp_seq;
    exp_seq    = {16'hA5A5, 1'b1};
    stat_data  = 16'hA5A5;
    stat_valid = 1'b1;
    @(posedge csr_aclk); #1;
    stat_valid = 1'b0;
    checks++;
    if (stat_ready !== 1'b0) begin
      failures++; $display("FAIL stat_full: stat_ready=%b want 0", stat_ready);
    end
    send_bits(17'h00000, 17, seq);
    checks++;
    if (seq !== exp_seq) begin
      failures++; $display("FAIL stat_seq: got %b want %b", seq, exp_seq);
    end
    checks++;
    if (stat_ready !== 1'b0) begin
      failures++; $display("FAIL stat_ready_early: got %b want 0", stat_ready);
    end
    checks++;
    if (esdi_confstat_data !== 1'b0) begin
      failures++; $display("FAIL stat_confstat_idle: got %b want 0", esdi_confstat_data);
    end
    @(posedge csr_aclk); #1;
    checks++;
    if (stat_ready !== 1'b1) begin
      failures++; $display("FAIL stat_ready: got %b want 1", stat_ready);
    end
    checks++;
    if (cmd_valid !== 1'b0) begin
      failures++; $display("FAIL stat_no_cmd: cmd_valid=%b want 0", cmd_valid);
    end
  endtask

  task automatic test_timeout;
    logic [16:0] seq;
    int          n;
    send_bits({16'hFFFF, 1'b1}, 5, seq);
    n = 0;
    while (frame_err !== 1'b1 && n < 100) begin
      @(posedge csr_aclk); #1; n++;
    end
    checks++;
    if (n !== 40) begin
      failures++; $display("FAIL timeout_clocks: frame_err after %0d clocks want 40", n);
    end
    @(posedge csr_aclk); #1;
    checks++;
    if (frame_err !== 1'b0) begin
      failures++; $display("FAIL timeout_pulse: frame_err=%b want 0", frame_err);
    end
    checks++;
    if (cmd_valid !== 1'b0) begin
      failures++; $display("FAIL timeout_no_cmd: cmd_valid=%b want 0", cmd_valid);
    end
    // 0x00FF has eight ones, so parity 1.
    cmd_frame("after_timeout", 16'h00FF, 1'b1, 1'b0);
    consume_cmd("after_timeout");
  endtask

  task automatic test_stall;
    logic [16:0] seq;
    logic [16:0] frame;
    int          n;
    bit          ack_seen;
    cmd_frame("stall_first", 16'h5555, 1'b1, 1'b0);
    frame = {16'h8001, 1'b1};
    esdi_command_data = frame[16];
    esdi_transfer_req = 1'b1;
    ack_seen = 1'b0;
    repeat (20) begin
      @(posedge csr_aclk); #1;
      if (esdi_transfer_ack !== 1'b0) ack_seen = 1'b1;
    end
    checks++;
    if (ack_seen !== 1'b0) begin
      failures++; $display("FAIL stall_ack: ack rose while cmd_valid held");
    end
    consume_cmd("stall");
    n = 0;
    while (esdi_transfer_ack !== 1'b1 && n < Bound) begin
      @(posedge csr_aclk); #1; n++;
    end
    checks++;
    if (esdi_transfer_ack !== 1'b1) begin
      failures++; $display("FAIL stall_resume: ack=%b want 1 after cmd_ready", esdi_transfer_ack);
    end
    esdi_transfer_req = 1'b0;
    n = 0;
    while (esdi_transfer_ack !== 1'b0 && n < Bound) begin
      @(posedge csr_aclk); #1; n++;
    end
    send_bits(frame << 1, 16, seq);
    @(posedge csr_aclk); #1;
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== 16'h8001) begin
      failures++;
      $display("FAIL stall_data: valid=%b data=%h want 1/8001", cmd_valid, cmd_data);
    end
    consume_cmd("stall_second");
  endtask

  task automatic test_reset_mid_frame;
    logic [16:0] seq;
    int          n;
    send_bits({16'hBEEF, 1'b0}, 8, seq);
    esdi_command_data = 1'b1;
    esdi_transfer_req = 1'b1;
    n = 0;
    while (esdi_transfer_ack !== 1'b1 && n < Bound) begin
      @(posedge csr_aclk); #1; n++;
    end
    checks++;
    if (esdi_transfer_ack !== 1'b1) begin
      failures++; $display("FAIL midreset_ack_pre: ack=%b want 1", esdi_transfer_ack);
    end
    #1;
    csr_aresetn = 1'b0;
    #1;
    check_reset_values("midreset");
    esdi_transfer_req = 1'b0;
    @(posedge csr_aclk); #1;
    csr_aresetn = 1'b1;
    repeat (2) @(posedge csr_aclk);
    #1;
    // 0xBEEF has thirteen ones, so parity 0.
    cmd_frame("after_reset", 16'hBEEF, 1'b0, 1'b0);
    consume_cmd("after_reset");
  endtask

  initial begin
    test_reset();
    test_cmd_good();
    test_cmd_parity_err();
    test_status();
    test_timeout();
    test_stall();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
